// File: rtl/seg_scan.sv
// Three-digit multiplexed 7-segment driver with frame-synchronous digit updates,
// leading-zero blanking and frame-counted blinking.
module seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] num_2,
    input  logic [3:0] num_1,
    input  logic [3:0] num_0,
    input  logic       load,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [2:0] dig_sel,
    output logic       frame_done,
    output logic       upd_pending
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_disp_2, r_disp_1, r_disp_0;
    logic [3:0]    r_pend_2, r_pend_1, r_pend_0;
    logic          r_upd;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;
    logic [6:0]    r_seg;
    logic [2:0]    r_dig;

    logic          w_tick;
    logic          w_boundary;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [2:0]    w_dig;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h40;
            4'd1:    f_decode = 7'h79;
            4'd2:    f_decode = 7'h24;
            4'd3:    f_decode = 7'h30;
            4'd4:    f_decode = 7'h19;
            4'd5:    f_decode = 7'h12;
            4'd6:    f_decode = 7'h02;
            4'd7:    f_decode = 7'h78;
            4'd8:    f_decode = 7'h00;
            4'd9:    f_decode = 7'h10;
            default: f_decode = 7'h3F;
        endcase
    endfunction

    assign w_tick      = (r_presc == PW'(SCAN_DIV - 1));
    assign w_boundary  = w_tick && (r_idx == 2'd2);
    assign frame_done  = w_boundary;
    assign upd_pending = r_upd;
    assign seg         = r_seg;
    assign dig_sel     = r_dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // A load landing on the boundary bypasses pending so it is never a frame late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_2 <= 4'd0;
            r_disp_1 <= 4'd0;
            r_disp_0 <= 4'd0;
            r_pend_2 <= 4'd0;
            r_pend_1 <= 4'd0;
            r_pend_0 <= 4'd0;
            r_upd    <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_disp_2 <= num_2;
                r_disp_1 <= num_1;
                r_disp_0 <= num_0;
            end else if (r_upd) begin
                r_disp_2 <= r_pend_2;
                r_disp_1 <= r_pend_1;
                r_disp_0 <= r_pend_0;
            end
            r_upd <= 1'b0;
        end else if (load) begin
            r_pend_2 <= num_2;
            r_pend_1 <= num_1;
            r_pend_0 <= num_0;
            r_upd    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (!blink_en) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_boundary) begin
            if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end
        end
    end

    always_comb begin
        w_digit = r_disp_0;
        w_blank = 1'b0;
        w_dig   = 3'b110;
        case (r_idx)
            2'd1: begin
                w_digit = r_disp_1;
                w_blank = (r_disp_2 == 4'd0) && (r_disp_1 == 4'd0);
                w_dig   = 3'b101;
            end
            2'd2: begin
                w_digit = r_disp_2;
                w_blank = (r_disp_2 == 4'd0);
                w_dig   = 3'b011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h7F;
            r_dig <= 3'b111;
        end else if (blink_en && !r_phase) begin
            r_seg <= 7'h7F;
            r_dig <= 3'b111;
        end else begin
            r_seg <= w_blank ? 7'h7F : f_decode(w_digit);
            r_dig <= w_dig;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, BLINK_FRAMES=2.
`timescale 1ns/1ps
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] num_2 = 4'd0, num_1 = 4'd0, num_0 = 4'd0;
    logic       load = 1'b0;
    logic       blink_en = 1'b0;
    logic [6:0] seg;
    logic [2:0] dig_sel;
    logic       frame_done;
    logic       upd_pending;

    int n_pass = 0;
    int n_checks = 0;

    seg_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .num_2      (num_2),
        .num_1      (num_1),
        .num_0      (num_0),
        .load       (load),
        .blink_en   (blink_en),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done),
        .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (frame_done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({seg, dig_sel, frame_done, upd_pending} !== {7'h7F, 3'b111, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got seg=%h dig=%b fd=%b up=%b, want 7f 111 0 0",
                     seg, dig_sel, frame_done, upd_pending);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h40, 3'b110})
            $display("FAIL reset_first_units: got seg=%h dig=%b, want 40 110", seg, dig_sel);
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h7F, 3'b101})
            $display("FAIL reset_tens_blank: got seg=%h dig=%b, want 7f 101", seg, dig_sel);
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h7F, 3'b011})
            $display("FAIL reset_hund_blank: got seg=%h dig=%b, want 7f 011", seg, dig_sel);
        else n_pass++;
    endtask

    task automatic test_deferred_load();
        bit ok;
        logic [6:0] es [3];
        logic [2:0] ed [3];
        es[0] = 7'h30; es[1] = 7'h24; es[2] = 7'h79;
        ed[0] = 3'b110; ed[1] = 3'b101; ed[2] = 3'b011;
        wait_fd(ok);
        n_checks++;
        if (!ok) $display("FAIL defer_align_timeout: got no frame_done, want frame_done within 40 cycles");
        else n_pass++;
        step();
        step();
        num_2 = 4'd1; num_1 = 4'd2; num_0 = 4'd3; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (upd_pending !== 1'b1) $display("FAIL defer_pending_set: got %b, want 1", upd_pending);
        else n_pass++;
        n_checks++;
        if ({seg, dig_sel} !== {7'h40, 3'b110})
            $display("FAIL defer_old_units: got seg=%h dig=%b, want 40 110", seg, dig_sel);
        else n_pass++;
        wait_fd(ok);
        n_checks++;
        if (!ok || upd_pending !== 1'b1)
            $display("FAIL defer_pending_at_fd: got fd_seen=%b up=%b, want 1 1", ok, upd_pending);
        else n_pass++;
        step();
        n_checks++;
        if ({frame_done, upd_pending} !== 2'b00)
            $display("FAIL defer_fd_pulse_clear: got fd=%b up=%b, want 0 0", frame_done, upd_pending);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({seg, dig_sel} !== {es[i/4], ed[i/4]})
                $display("FAIL defer_scan_%0d: got seg=%h dig=%b, want %h %b",
                         i, seg, dig_sel, es[i/4], ed[i/4]);
            else n_pass++;
        end
    endtask

    task automatic test_blanking();
        bit ok;
        logic [6:0] es [3];
        logic [2:0] ed [3];
        es[0] = 7'h78; es[1] = 7'h7F; es[2] = 7'h7F;
        ed[0] = 3'b110; ed[1] = 3'b101; ed[2] = 3'b011;
        num_2 = 4'd0; num_1 = 4'd0; num_0 = 4'd7; load = 1'b1;
        step();
        load = 1'b0;
        wait_fd(ok);
        step();
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({seg, dig_sel} !== {es[i/4], ed[i/4]})
                $display("FAIL blank007_%0d: got seg=%h dig=%b, want %h %b",
                         i, seg, dig_sel, es[i/4], ed[i/4]);
            else n_pass++;
        end
        num_2 = 4'd0; num_1 = 4'd0; num_0 = 4'd0; load = 1'b1;
        step();
        load = 1'b0;
        wait_fd(ok);
        step();
        step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h40, 3'b110})
            $display("FAIL blank000_units: got seg=%h dig=%b, want 40 110", seg, dig_sel);
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h7F, 3'b101})
            $display("FAIL blank000_tens: got seg=%h dig=%b, want 7f 101", seg, dig_sel);
        else n_pass++;
    endtask

    task automatic test_overwrite();
        bit ok;
        logic [6:0] es [3];
        logic [2:0] ed [3];
        es[0] = 7'h02; es[1] = 7'h12; es[2] = 7'h19;
        ed[0] = 3'b110; ed[1] = 3'b101; ed[2] = 3'b011;
        wait_fd(ok);
        step();
        step();
        num_2 = 4'd9; num_1 = 4'd9; num_0 = 4'd9; load = 1'b1;
        step();
        load = 1'b0;
        step();
        num_2 = 4'd4; num_1 = 4'd5; num_0 = 4'd6; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if ({seg, dig_sel, upd_pending} !== {7'h40, 3'b110, 1'b1})
            $display("FAIL ovw_hold_units: got seg=%h dig=%b up=%b, want 40 110 1",
                     seg, dig_sel, upd_pending);
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h7F, 3'b101})
            $display("FAIL ovw_hold_tens: got seg=%h dig=%b, want 7f 101", seg, dig_sel);
        else n_pass++;
        wait_fd(ok);
        step();
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({seg, dig_sel} !== {es[i/4], ed[i/4]})
                $display("FAIL ovw_scan_%0d: got seg=%h dig=%b, want %h %b",
                         i, seg, dig_sel, es[i/4], ed[i/4]);
            else n_pass++;
        end
    endtask

    task automatic test_coincident();
        bit ok;
        logic [6:0] es [3];
        logic [2:0] ed [3];
        es[0] = 7'h12; es[1] = 7'h3F; es[2] = 7'h10;
        ed[0] = 3'b110; ed[1] = 3'b101; ed[2] = 3'b011;
        wait_fd(ok);
        n_checks++;
        if (!ok) $display("FAIL coin_align_timeout: got no frame_done, want frame_done within 40 cycles");
        else n_pass++;
        num_2 = 4'd9; num_1 = 4'd12; num_0 = 4'd5; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (upd_pending !== 1'b0) $display("FAIL coin_pending: got %b, want 0", upd_pending);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({seg, dig_sel, upd_pending} !== {es[i/4], ed[i/4], 1'b0})
                $display("FAIL coin_scan_%0d: got seg=%h dig=%b up=%b, want %h %b 0",
                         i, seg, dig_sel, upd_pending, es[i/4], ed[i/4]);
            else n_pass++;
        end
    endtask

    // Entered right after a boundary edge; display holds 9/12/5.
    task automatic test_blink();
        logic [6:0] es [3];
        logic [2:0] ed [3];
        logic       off;
        int         s;
        es[0] = 7'h12; es[1] = 7'h3F; es[2] = 7'h10;
        ed[0] = 3'b110; ed[1] = 3'b101; ed[2] = 3'b011;
        blink_en = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            step();
            off = ((i >= 25) && (i <= 48)) || ((i >= 73) && (i <= 76));
            s = ((i - 1) / 4) % 3;
            n_checks++;
            if (off) begin
                if ({seg, dig_sel} !== {7'h7F, 3'b111})
                    $display("FAIL blink_off_%0d: got seg=%h dig=%b, want 7f 111", i, seg, dig_sel);
                else n_pass++;
            end else begin
                if ({seg, dig_sel} !== {es[s], ed[s]})
                    $display("FAIL blink_on_%0d: got seg=%h dig=%b, want %h %b",
                             i, seg, dig_sel, es[s], ed[s]);
                else n_pass++;
            end
            if (i == 76) blink_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_fd(ok);
        step();
        step();
        num_2 = 4'd4; num_1 = 4'd5; num_0 = 4'd6; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (upd_pending !== 1'b1) $display("FAIL rstmid_pending_set: got %b, want 1", upd_pending);
        else n_pass++;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seg, dig_sel, frame_done, upd_pending} !== {7'h7F, 3'b111, 1'b0, 1'b0})
            $display("FAIL rstmid_async: got seg=%h dig=%b fd=%b up=%b, want 7f 111 0 0",
                     seg, dig_sel, frame_done, upd_pending);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h40, 3'b110})
            $display("FAIL rstmid_units: got seg=%h dig=%b, want 40 110", seg, dig_sel);
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if ({seg, dig_sel} !== {7'h7F, 3'b101})
            $display("FAIL rstmid_tens: got seg=%h dig=%b, want 7f 101", seg, dig_sel);
        else n_pass++;
        wait_fd(ok);
        step();
        step();
        n_checks++;
        if ({seg, dig_sel, upd_pending} !== {7'h40, 3'b110, 1'b0})
            $display("FAIL rstmid_discard: got seg=%h dig=%b up=%b, want 40 110 0",
                     seg, dig_sel, upd_pending);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_deferred_load();
        test_blanking();
        test_overwrite();
        test_coincident();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
